// File: rtl/door_access_if.sv
// -----------------------------------------------------------------------------
// door_access_if
// Bundles the key/button inputs and the status outputs of the door access
// sequencer so they can be passed as a single port.
//
//   cin1..cin4      keys for digits 1..4, active-low, debounced
//   enter           submit the entered code (rising edge acts)
//   change          request a password change while access is granted
//   comfirm         commit the new password while in change mode
//   reset_password  reload the default password while idle
//   green_LED       access granted
//   red_LED         access denied / locked out
//   green_led2      password-change mode active
//   code_disp       entry buffer, one nibble per digit, to the 7-seg decode
//   entry_cnt       digits captured so far (0..4)
//   fail_cnt        consecutive failed attempts
//   state           FSM state, IDLE=0 .. NEWPW=6
//
// master: the side that drives the keys (testbench / input conditioning)
// slave : the sequencer itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface door_access_if;
    logic        cin1;
    logic        cin2;
    logic        cin3;
    logic        cin4;
    logic        enter;
    logic        change;
    logic        comfirm;
    logic        reset_password;
    logic        green_LED;
    logic        red_LED;
    logic        green_led2;
    logic [15:0] code_disp;
    logic [2:0]  entry_cnt;
    logic [1:0]  fail_cnt;
    logic [2:0]  state;

    modport master (
        output cin1, cin2, cin3, cin4, enter, change, comfirm, reset_password,
        input  green_LED, red_LED, green_led2, code_disp, entry_cnt, fail_cnt, state
    );

    modport slave (
        input  cin1, cin2, cin3, cin4, enter, change, comfirm, reset_password,
        output green_LED, red_LED, green_led2, code_disp, entry_cnt, fail_cnt, state
    );
endinterface

// File: rtl/door_access_sequencer.sv
// -----------------------------------------------------------------------------
// door_access_sequencer
// Central FSM of the door security system. Captures 4-digit codes from the
// active-low keys, compares them with the stored password, drives the
// grant/deny LEDs, runs the password-change flow and enforces a timed lockout
// after MAX_FAIL consecutive failures.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state, loads DEFAULT_PW
//   bus    door_access_if.slave: key/button inputs and status outputs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module door_access_sequencer #(
    parameter logic [15:0] DEFAULT_PW   = 16'h1234,
    parameter int          MAX_FAIL     = 3,
    parameter int          GRANT_CYCLES = 20,
    parameter int          DENY_CYCLES  = 10,
    parameter int          LOCK_CYCLES  = 50
) (
    input  logic          clk,
    input  logic          reset,
    door_access_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        GRANTED = 3'd3,
        DENIED  = 3'd4,
        LOCKOUT = 3'd5,
        NEWPW   = 3'd6
    } state_t;

    localparam logic [7:0] GRANT_T  = 8'(GRANT_CYCLES);
    localparam logic [7:0] DENY_T   = 8'(DENY_CYCLES);
    localparam logic [7:0] LOCK_T   = 8'(LOCK_CYCLES);
    localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  fail_q, fail_d;
    logic [15:0] pw_q, pw_d;
    logic [15:0] disp_q, disp_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        green_q, red_q, green2_q;

    // Edge detection: previous sampled levels of every edge-sensitive input.
    logic [3:0]  cin_now, cin_prev;
    logic        enter_prev, change_prev, comfirm_prev;
    logic        enter_edge, change_edge, comfirm_edge;
    logic [3:0]  press;
    logic        key_hit;
    logic [3:0]  key_digit;
    logic        capture_ok;

    assign cin_now      = {bus.cin4, bus.cin3, bus.cin2, bus.cin1};
    // A key press is a high-to-low transition; it acts on the same edge that
    // first samples the low level.
    assign press        = cin_prev & ~cin_now;
    assign enter_edge   = bus.enter   & ~enter_prev;
    assign change_edge  = bus.change  & ~change_prev;
    assign comfirm_edge = bus.comfirm & ~comfirm_prev;

    // Only a single key press per cycle is a valid digit; simultaneous presses
    // are ambiguous and dropped.
    always_comb begin
        key_hit   = 1'b0;
        key_digit = 4'd0;
        case (press)
            4'b0001: begin key_hit = 1'b1; key_digit = 4'd1; end
            4'b0010: begin key_hit = 1'b1; key_digit = 4'd2; end
            4'b0100: begin key_hit = 1'b1; key_digit = 4'd3; end
            4'b1000: begin key_hit = 1'b1; key_digit = 4'd4; end
            default: ;
        endcase
    end

    // Once four digits are held the buffer is frozen and the count saturates.
    assign capture_ok = key_hit && (cnt_q < 3'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cin_prev     <= 4'hF;
            enter_prev   <= 1'b0;
            change_prev  <= 1'b0;
            comfirm_prev <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every register samples the pre-edge values of its neighbours.
            cin_prev     <= cin_now;
            enter_prev   <= bus.enter;
            change_prev  <= bus.change;
            comfirm_prev <= bus.comfirm;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; any path that
        // left one unassigned would infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        pw_d    = pw_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                disp_d = '0;
                cnt_d  = '0;
                if (bus.reset_password) begin
                    pw_d = DEFAULT_PW;
                end else if (key_hit) begin
                    disp_d  = {12'h000, key_digit};
                    cnt_d   = 3'd1;
                    state_d = ENTRY;
                end
            end

            ENTRY: begin
                // Short codes are submitted as-is and fail in CHECK.
                if (enter_edge) begin
                    state_d = CHECK;
                end else if (capture_ok) begin
                    disp_d = {disp_q[11:0], key_digit};
                    cnt_d  = cnt_q + 3'd1;
                end
            end

            CHECK: begin
                if (cnt_q == 3'd4 && disp_q == pw_q) begin
                    fail_d  = '0;
                    timer_d = GRANT_T;
                    state_d = GRANTED;
                end else if (({1'b0, fail_q} + 3'd1) == FAIL_MAX) begin
                    fail_d  = fail_q + 2'd1;
                    timer_d = LOCK_T;
                    state_d = LOCKOUT;
                end else begin
                    fail_d  = fail_q + 2'd1;
                    timer_d = DENY_T;
                    state_d = DENIED;
                end
            end

            GRANTED: begin
                // change wins over expiry, even on the final timer cycle.
                if (change_edge) begin
                    disp_d  = '0;
                    cnt_d   = '0;
                    state_d = NEWPW;
                end else if (timer_q == 8'd1) begin
                    disp_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            NEWPW: begin
                if (comfirm_edge) begin
                    if (cnt_q == 3'd4) begin
                        pw_d    = disp_q;
                        disp_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        // Incomplete new password: reject without counting it
                        // as a failed access attempt.
                        timer_d = DENY_T;
                        state_d = DENIED;
                    end
                end else if (capture_ok) begin
                    disp_d = {disp_q[11:0], key_digit};
                    cnt_d  = cnt_q + 3'd1;
                end
            end

            DENIED: begin
                if (timer_q == 8'd1) begin
                    disp_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            LOCKOUT: begin
                if (timer_q == 8'd1) begin
                    fail_d  = '0;
                    disp_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            default: begin
                disp_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            fail_q   <= '0;
            // NOTE: the password register is reset like any other flop so the
            // lock always comes up with a known code.
            pw_q     <= DEFAULT_PW;
            disp_q   <= '0;
            cnt_q    <= '0;
            green_q  <= 1'b0;
            red_q    <= 1'b0;
            green2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
            pw_q     <= pw_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            // LEDs are decoded from the next state so they switch together
            // with the state register.
            green_q  <= (state_d == GRANTED);
            red_q    <= (state_d == DENIED) || (state_d == LOCKOUT);
            green2_q <= (state_d == NEWPW);
        end
    end

    assign bus.state      = state_q;
    assign bus.code_disp  = disp_q;
    assign bus.entry_cnt  = cnt_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.green_LED  = green_q;
    assign bus.red_LED    = red_q;
    assign bus.green_led2 = green2_q;

endmodule

// File: tb/tb_door_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_door_access_sequencer
// Self-checking bench for door_access_sequencer: a vector table for digit
// capture, hand-written multi-cycle sequences, and a randomized run compared
// against a queue-based reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_door_access_sequencer;

    localparam int MAX_FAIL     = 3;
    localparam int GRANT_CYCLES = 20;
    localparam int DENY_CYCLES  = 10;
    localparam int LOCK_CYCLES  = 50;

    localparam int S_IDLE    = 0;
    localparam int S_ENTRY   = 1;
    localparam int S_CHECK   = 2;
    localparam int S_GRANTED = 3;
    localparam int S_DENIED  = 4;
    localparam int S_LOCKOUT = 5;
    localparam int S_NEWPW   = 6;

    logic clk = 1'b0;
    logic reset;

    door_access_if bus ();

    door_access_sequencer #(
        .DEFAULT_PW   (16'h1234),
        .MAX_FAIL     (MAX_FAIL),
        .GRANT_CYCLES (GRANT_CYCLES),
        .DENY_CYCLES  (DENY_CYCLES),
        .LOCK_CYCLES  (LOCK_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] k);
        {bus.cin4, bus.cin3, bus.cin2, bus.cin1} = k;
    endtask

    task automatic idle_inputs();
        set_keys(4'hF);
        bus.enter          = 1'b0;
        bus.change         = 1'b0;
        bus.comfirm        = 1'b0;
        bus.reset_password = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic press(input int d);
        logic [3:0] k;
        k = 4'hF;
        k[d-1] = 1'b0;
        set_keys(k);
        tick();
        set_keys(4'hF);
        tick();
    endtask

    // Presses the n lowest nibbles of code, most significant first.
    task automatic keys(input logic [15:0] code, input int n);
        for (int i = 0; i < n; i++) press(int'(code[4*(n-1-i) +: 4]));
    endtask

    task automatic enter_pulse();
        bus.enter = 1'b1;
        tick();
        check("check_state", bus.state, S_CHECK);
        bus.enter = 1'b0;
        tick();
    endtask

    // Counts samples spent in state s, starting with the current one.
    task automatic dwell(input int s, output int n);
        n = 0;
        while (bus.state == 3'(s) && n < 400) begin
            n++;
            tick();
        end
    endtask

    // ---------------- reference model ----------------
    int   m_mode, m_timer, m_fail;
    int   m_dig[$];
    int   m_pw[4];
    logic [3:0] m_pcin;
    logic m_pen, m_pch, m_pcf;

    task automatic model_reset();
        m_mode  = S_IDLE;
        m_timer = 0;
        m_fail  = 0;
        m_dig.delete();
        m_pw    = '{1, 2, 3, 4};
        m_pcin  = 4'hF;
        m_pen   = 1'b0;
        m_pch   = 1'b0;
        m_pcf   = 1'b0;
    endtask

    function automatic int model_disp();
        int v;
        v = 0;
        foreach (m_dig[i]) v = v * 16 + m_dig[i];
        return v;
    endfunction

    function automatic bit model_match();
        if (m_dig.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_dig[i] != m_pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic [3:0] k, input logic en, input logic ch,
                              input logic cf, input logic rp);
        int  presses[$];
        bit  single, en_e, ch_e, cf_e;
        int  d;
        for (int i = 0; i < 4; i++) if (m_pcin[i] && !k[i]) presses.push_back(i + 1);
        single = (presses.size() == 1);
        d      = single ? presses[0] : 0;
        en_e   = en && !m_pen;
        ch_e   = ch && !m_pch;
        cf_e   = cf && !m_pcf;
        case (m_mode)
            S_IDLE: begin
                m_dig.delete();
                if (rp) m_pw = '{1, 2, 3, 4};
                else if (single) begin
                    m_dig.push_back(d);
                    m_mode = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (en_e) m_mode = S_CHECK;
                else if (single && m_dig.size() < 4) m_dig.push_back(d);
            end
            S_CHECK: begin
                if (model_match()) begin
                    m_fail = 0; m_timer = GRANT_CYCLES; m_mode = S_GRANTED;
                end else begin
                    m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_timer = LOCK_CYCLES; m_mode = S_LOCKOUT;
                    end else begin
                        m_timer = DENY_CYCLES; m_mode = S_DENIED;
                    end
                end
            end
            S_GRANTED: begin
                if (ch_e) begin
                    m_dig.delete(); m_mode = S_NEWPW;
                end else if (m_timer == 1) begin
                    m_dig.delete(); m_mode = S_IDLE;
                end else m_timer--;
            end
            S_NEWPW: begin
                if (cf_e) begin
                    if (m_dig.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_pw[i] = m_dig[i];
                        m_dig.delete(); m_mode = S_IDLE;
                    end else begin
                        m_timer = DENY_CYCLES; m_mode = S_DENIED;
                    end
                end else if (single && m_dig.size() < 4) m_dig.push_back(d);
            end
            default: begin // DENIED, LOCKOUT
                if (m_timer == 1) begin
                    if (m_mode == S_LOCKOUT) m_fail = 0;
                    m_dig.delete(); m_mode = S_IDLE;
                end else m_timer--;
            end
        endcase
        m_pcin = k;
        m_pen  = en;
        m_pch  = ch;
        m_pcf  = cf;
    endtask

    task automatic compare_model();
        check("rnd_state",  bus.state,      m_mode);
        check("rnd_cnt",    bus.entry_cnt,  m_dig.size());
        check("rnd_disp",   bus.code_disp,  model_disp());
        check("rnd_fail",   bus.fail_cnt,   m_fail);
        check("rnd_green",  bus.green_LED,  m_mode == S_GRANTED);
        check("rnd_red",    bus.red_LED,    m_mode == S_DENIED || m_mode == S_LOCKOUT);
        check("rnd_green2", bus.green_led2, m_mode == S_NEWPW);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  cin;
        logic        enter;
        logic [2:0]  st;
        logic [2:0]  cnt;
        logic [15:0] disp;
        logic        green;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, m;

        // {cin, enter} -> {state, entry_cnt, code_disp, green_LED}
        vecs.push_back('{4'hF, 1'b1, 3'd0, 3'd0, 16'h0000, 1'b0}); // enter ignored in IDLE
        vecs.push_back('{4'hF, 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0});
        vecs.push_back('{4'hE, 1'b0, 3'd1, 3'd1, 16'h0001, 1'b0}); // key 1
        vecs.push_back('{4'hF, 1'b0, 3'd1, 3'd1, 16'h0001, 1'b0});
        vecs.push_back('{4'hD, 1'b0, 3'd1, 3'd2, 16'h0012, 1'b0}); // key 2
        vecs.push_back('{4'hF, 1'b0, 3'd1, 3'd2, 16'h0012, 1'b0});
        vecs.push_back('{4'hC, 1'b0, 3'd1, 3'd2, 16'h0012, 1'b0}); // keys 1+2 together
        vecs.push_back('{4'hF, 1'b0, 3'd1, 3'd2, 16'h0012, 1'b0});
        vecs.push_back('{4'hB, 1'b0, 3'd1, 3'd3, 16'h0123, 1'b0}); // key 3
        vecs.push_back('{4'hF, 1'b0, 3'd1, 3'd3, 16'h0123, 1'b0});
        vecs.push_back('{4'h7, 1'b0, 3'd1, 3'd4, 16'h1234, 1'b0}); // key 4
        vecs.push_back('{4'hF, 1'b0, 3'd1, 3'd4, 16'h1234, 1'b0});
        vecs.push_back('{4'h7, 1'b0, 3'd1, 3'd4, 16'h1234, 1'b0}); // fifth key ignored
        vecs.push_back('{4'hF, 1'b1, 3'd2, 3'd4, 16'h1234, 1'b0}); // CHECK
        vecs.push_back('{4'hF, 1'b1, 3'd3, 3'd4, 16'h1234, 1'b1}); // GRANTED
        vecs.push_back('{4'hF, 1'b0, 3'd3, 3'd4, 16'h1234, 1'b1});

        apply_reset();
        check("rst_state",  bus.state,      0);
        check("rst_leds",   {bus.green_LED, bus.red_LED, bus.green_led2}, 0);
        check("rst_disp",   bus.code_disp,  0);
        check("rst_cnt",    bus.entry_cnt,  0);
        check("rst_fail",   bus.fail_cnt,   0);

        foreach (vecs[i]) begin
            set_keys(vecs[i].cin);
            bus.enter = vecs[i].enter;
            tick();
            check($sformatf("vec%0d_state", i), bus.state,     vecs[i].st);
            check($sformatf("vec%0d_cnt", i),   bus.entry_cnt, vecs[i].cnt);
            check($sformatf("vec%0d_disp", i),  bus.code_disp, vecs[i].disp);
            check($sformatf("vec%0d_green", i), bus.green_LED, vecs[i].green);
        end

        // Grant with the default password, GRANT_CYCLES of green.
        apply_reset();
        keys(16'h1234, 4);
        check("g_cnt",  bus.entry_cnt, 4);
        check("g_disp", bus.code_disp, 16'h1234);
        enter_pulse();
        check("g_state", bus.state, S_GRANTED);
        check("g_green", bus.green_LED, 1);
        dwell(S_GRANTED, n);
        check("g_cycles", n, GRANT_CYCLES);
        check("g_idle",   bus.state, S_IDLE);
        check("g_clear",  bus.code_disp, 0);
        check("g_led_off", bus.green_LED, 0);

        // Two denials, then lockout.
        for (int f = 1; f <= 2; f++) begin
            keys(16'h1111, 4);
            enter_pulse();
            check("d_state", bus.state, S_DENIED);
            check("d_red",   bus.red_LED, 1);
            check("d_fail",  bus.fail_cnt, f);
            dwell(S_DENIED, n);
            check("d_cycles", n, DENY_CYCLES);
        end
        keys(16'h1111, 4);
        enter_pulse();
        check("l_state", bus.state, S_LOCKOUT);
        check("l_red",   bus.red_LED, 1);
        set_keys(4'hE);
        tick();
        check("l_key_ignored", bus.code_disp, 16'h1111);
        set_keys(4'hF);
        tick();
        dwell(S_LOCKOUT, m);
        check("l_cycles", m + 2, LOCK_CYCLES);
        check("l_exit_state", bus.state, S_IDLE);
        check("l_exit_fail",  bus.fail_cnt, 0);

        // Password change to 3333.
        keys(16'h1234, 4);
        enter_pulse();
        check("c_grant", bus.state, S_GRANTED);
        bus.change = 1'b1;
        tick();
        check("c_newpw",  bus.state, S_NEWPW);
        check("c_green2", bus.green_led2, 1);
        check("c_green",  bus.green_LED, 0);
        check("c_clear",  {bus.code_disp, 13'(bus.entry_cnt)}, 0);
        bus.change = 1'b0;
        keys(16'h3333, 4);
        check("c_disp", bus.code_disp, 16'h3333);
        bus.comfirm = 1'b1;
        tick();
        check("c_idle",       bus.state, S_IDLE);
        check("c_green2_off", bus.green_led2, 0);
        bus.comfirm = 1'b0;
        tick();
        keys(16'h1234, 4);
        enter_pulse();
        check("c_old_denied", bus.state, S_DENIED);
        check("c_old_fail",   bus.fail_cnt, 1);
        dwell(S_DENIED, n);
        keys(16'h3333, 4);
        enter_pulse();
        check("c_new_grant", bus.state, S_GRANTED);
        check("c_new_fail",  bus.fail_cnt, 0);
        dwell(S_GRANTED, n);

        // reset_password in IDLE restores 1234; set 4444 for the reset test.
        bus.reset_password = 1'b1;
        tick();
        bus.reset_password = 1'b0;
        tick();
        keys(16'h1234, 4);
        enter_pulse();
        check("rp_grant", bus.state, S_GRANTED);
        bus.change = 1'b1;
        tick();
        bus.change = 1'b0;
        keys(16'h4444, 4);
        bus.comfirm = 1'b1;
        tick();
        bus.comfirm = 1'b0;
        tick();
        keys(16'h4444, 4);
        enter_pulse();
        check("p4_grant", bus.state, S_GRANTED);
        bus.change = 1'b1;
        tick();
        bus.change = 1'b0;
        press(2);
        press(1);
        check("ar_cnt_before", bus.entry_cnt, 2);
        #2 reset = 1'b1;
        #1;
        check("ar_state", bus.state, 0);
        check("ar_leds",  {bus.green_LED, bus.red_LED, bus.green_led2}, 0);
        check("ar_disp",  bus.code_disp, 0);
        check("ar_cnt",   bus.entry_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        keys(16'h1234, 4);
        enter_pulse();
        check("ar_default_pw", bus.state, S_GRANTED);
        dwell(S_GRANTED, n);

        // Short code is denied.
        keys(16'h0012, 2);
        enter_pulse();
        check("s_state", bus.state, S_DENIED);
        check("s_fail",  bus.fail_cnt, 1);
        dwell(S_DENIED, n);

        // change on the final grant cycle, then short comfirm.
        keys(16'h1234, 4);
        enter_pulse();
        repeat (GRANT_CYCLES - 1) tick();
        check("fc_still_granted", bus.state, S_GRANTED);
        bus.change = 1'b1;
        tick();
        check("fc_newpw", bus.state, S_NEWPW);
        bus.change = 1'b0;
        keys(16'h0123, 3);
        bus.comfirm = 1'b1;
        tick();
        check("sc_denied", bus.state, S_DENIED);
        check("sc_fail",   bus.fail_cnt, 0);
        bus.comfirm = 1'b0;
        dwell(S_DENIED, n);
        check("sc_cycles", n, DENY_CYCLES);
        keys(16'h1234, 4);
        enter_pulse();
        check("sc_pw_kept", bus.state, S_GRANTED);

        // Randomized run against the reference model.
        apply_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] k;
            logic en, ch, cf, rp;
            int r;
            k = 4'hF;
            r = $urandom_range(0, 9);
            if (r < 2) k[$urandom_range(0, 3)] = 1'b0;
            else if (r < 4 && m_dig.size() < 4) k[m_pw[m_dig.size()] - 1] = 1'b0;
            else if (r == 4) k = 4'($urandom);
            en = ($urandom_range(0, 5) == 0);
            ch = ($urandom_range(0, 5) == 0);
            cf = ($urandom_range(0, 7) == 0);
            rp = ($urandom_range(0, 31) == 0);
            set_keys(k);
            bus.enter          = en;
            bus.change         = ch;
            bus.comfirm        = cf;
            bus.reset_password = rp;
            model_step(k, en, ch, cf, rp);
            tick();
            compare_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
